// File: rtl/debounce_botones.sv
// Per-button two-flop synchronizer, debounce FSM and rising-edge one-shot.
// Feeds clean load strobes for operand A, opcode and operand B.
`timescale 1ns/1ps

module debounce_botones #(
  parameter int CANT_BOTONES_ALU = 4,
  parameter int CICLOS_ESTABLES  = 8,
  parameter int BITS_CONTADOR    = 20
) (
  input  logic                        i_clock,
  input  logic                        i_reset,
  input  logic [CANT_BOTONES_ALU-1:0] i_botones,
  output logic [CANT_BOTONES_ALU-1:0] o_botones_estables,
  output logic [CANT_BOTONES_ALU-1:0] o_pulsos
);

  typedef enum logic [1:0] {
    ESTABLE_BAJO,
    VALIDANDO_ALTO,
    ESTABLE_ALTO,
    VALIDANDO_BAJO
  } estado_t;

  localparam logic [BITS_CONTADOR-1:0] CNT_FINAL = BITS_CONTADOR'(CICLOS_ESTABLES - 1);
  localparam logic [BITS_CONTADOR-1:0] CNT_UNO   = BITS_CONTADOR'(1);

  logic [CANT_BOTONES_ALU-1:0] sincA_q;
  logic [CANT_BOTONES_ALU-1:0] sincB_q;

  // Only sincB_q is allowed into the debounce logic; sincA_q may be metastable.
  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      sincA_q <= '0;
      sincB_q <= '0;
    end else begin
      sincA_q <= i_botones;
      sincB_q <= sincA_q;
    end
  end

  for (genvar g = 0; g < CANT_BOTONES_ALU; g++) begin : g_canal
    estado_t                  estado_q, estado_d;
    logic [BITS_CONTADOR-1:0] cnt_q, cnt_d;
    logic                     estable_q, estable_d;
    logic                     pulso_q, pulso_d;
    logic                     s;

    assign s = sincB_q[g];

    always_comb begin
      estado_d = estado_q;
      cnt_d    = '0;
      case (estado_q)
        ESTABLE_BAJO: begin
          if (s) begin
            estado_d = VALIDANDO_ALTO;
            cnt_d    = CNT_UNO;
          end
        end
        VALIDANDO_ALTO: begin
          if (!s) begin
            estado_d = ESTABLE_BAJO;
          end else if (cnt_q == CNT_FINAL) begin
            estado_d = ESTABLE_ALTO;
          end else begin
            cnt_d = cnt_q + CNT_UNO;
          end
        end
        ESTABLE_ALTO: begin
          if (!s) begin
            estado_d = VALIDANDO_BAJO;
            cnt_d    = CNT_UNO;
          end
        end
        VALIDANDO_BAJO: begin
          if (s) begin
            estado_d = ESTABLE_ALTO;
          end else if (cnt_q == CNT_FINAL) begin
            estado_d = ESTABLE_BAJO;
          end else begin
            cnt_d = cnt_q + CNT_UNO;
          end
        end
        default: begin
          estado_d = ESTABLE_BAJO;
        end
      endcase

      // Outputs are computed from the next state so they register on the same edge.
      estable_d = (estado_d == ESTABLE_ALTO) || (estado_d == VALIDANDO_BAJO);
      pulso_d   = (estado_q == VALIDANDO_ALTO) && (estado_d == ESTABLE_ALTO);
    end

    always_ff @(posedge i_clock or negedge i_reset) begin
      if (!i_reset) begin
        estado_q  <= ESTABLE_BAJO;
        cnt_q     <= '0;
        estable_q <= 1'b0;
        pulso_q   <= 1'b0;
      end else begin
        estado_q  <= estado_d;
        cnt_q     <= cnt_d;
        estable_q <= estable_d;
        pulso_q   <= pulso_d;
      end
    end

    assign o_botones_estables[g] = estable_q;
    assign o_pulsos[g]           = pulso_q;
  end

endmodule

// File: tb/tb_debounce_botones.sv
// Directed bench for debounce_botones with a per-cycle scoreboard driven by a
// run-length reference model of synchronizer plus debounce.
`timescale 1ns/1ps

module tb_debounce_botones;

  localparam int N = 4;
  localparam int C = 8;

  typedef struct packed {
    logic [N-1:0] est;
    logic [N-1:0] pul;
  } expect_t;

  logic         clock = 1'b0;
  logic         iReset;
  logic [N-1:0] iBotones;
  logic [N-1:0] oEstables;
  logic [N-1:0] oPulsos;

  expect_t      scoreboard[$];
  int           testsRun    = 0;
  int           testsFailed = 0;
  logic [N-1:0] mS1, mS2, mStable;
  int           mRun[N];
  int           pulseCount[N];

  debounce_botones #(
    .CANT_BOTONES_ALU(N),
    .CICLOS_ESTABLES (C),
    .BITS_CONTADOR   (20)
  ) dut (
    .i_clock           (clock),
    .i_reset           (iReset),
    .i_botones         (iBotones),
    .o_botones_estables(oEstables),
    .o_pulsos          (oPulsos)
  );

  always #2.5 clock = ~clock;

  function automatic void modelReset();
    mS1     = '0;
    mS2     = '0;
    mStable = '0;
    for (int i = 0; i < N; i++) mRun[i] = 0;
  endfunction

  function automatic void clearCounts();
    for (int i = 0; i < N; i++) pulseCount[i] = 0;
  endfunction

  task automatic checkOutput(input string tag, input logic [N-1:0] got, input logic [N-1:0] want);
    testsRun++;
    assert (got === want) else begin
      testsFailed++;
      $error("[TB] FAIL %s: observed %b expected %b", tag, got, want);
    end
  endtask

  task automatic checkCount(input string tag, input int got, input int want);
    testsRun++;
    assert (got === want) else begin
      testsFailed++;
      $error("[TB] FAIL %s: observed %0d expected %0d", tag, got, want);
    end
  endtask

  // One clock edge: model advances with pre-edge inputs, DUT is checked 1 ns later.
  task automatic tick(input string tag);
    logic [N-1:0] capIn;
    logic         capRst;
    logic [N-1:0] newPul;
    expect_t      e;
    capIn  = iBotones;
    capRst = iReset;
    newPul = '0;
    @(posedge clock);
    if (!capRst) begin
      modelReset();
    end else begin
      for (int i = 0; i < N; i++) begin
        if (mS2[i] != mStable[i]) begin
          mRun[i]++;
          if (mRun[i] == C) begin
            mStable[i] = mS2[i];
            mRun[i]    = 0;
            newPul[i]  = mS2[i];
          end
        end else begin
          mRun[i] = 0;
        end
      end
      mS2 = mS1;
      mS1 = capIn;
    end
    e.est = mStable;
    e.pul = newPul;
    scoreboard.push_back(e);
    #1;
    e = scoreboard.pop_front();
    checkOutput({tag, "/estables"}, oEstables, e.est);
    checkOutput({tag, "/pulsos"}, oPulsos, e.pul);
    for (int i = 0; i < N; i++) pulseCount[i] += int'(oPulsos[i]);
  endtask

  task automatic applyStimulus(input logic [N-1:0] b, input int n, input string tag);
    iBotones = b;
    repeat (n) tick(tag);
  endtask

  initial begin
    iReset   = 1'b0;
    iBotones = 4'b1111;
    modelReset();
    clearCounts();
    #1;
    checkOutput("reset_async_est", oEstables, 4'b0000);
    checkOutput("reset_async_pul", oPulsos, 4'b0000);

    // Reset held with all buttons pressed, then released.
    applyStimulus(4'b1111, 4, "reset_hold");
    iReset = 1'b1;
    applyStimulus(4'b1111, 9, "reset_rel");
    checkOutput("reset_rel_e9_est", oEstables, 4'b0000);
    tick("reset_rel");
    checkOutput("reset_rel_e10_est", oEstables, 4'b1111);
    checkOutput("reset_rel_e10_pul", oPulsos, 4'b1111);
    tick("reset_rel");
    checkOutput("reset_rel_e11_pul", oPulsos, 4'b0000);
    applyStimulus(4'b0000, 12, "reset_unpress");
    checkOutput("reset_unpress_est", oEstables, 4'b0000);

    // Clean press and release on channel 0.
    clearCounts();
    applyStimulus(4'b0001, 9, "clean");
    checkOutput("clean_e9_est", oEstables, 4'b0000);
    tick("clean");
    checkOutput("clean_e10_est", oEstables, 4'b0001);
    checkOutput("clean_e10_pul", oPulsos, 4'b0001);
    tick("clean");
    checkOutput("clean_e11_pul", oPulsos, 4'b0000);
    applyStimulus(4'b0001, 9, "clean_hold");
    applyStimulus(4'b0000, 9, "clean_rel");
    checkOutput("clean_rel_e9_est", oEstables, 4'b0001);
    tick("clean_rel");
    checkOutput("clean_rel_e10_est", oEstables, 4'b0000);
    checkOutput("clean_rel_e10_pul", oPulsos, 4'b0000);
    checkCount("clean_pulse_count", pulseCount[0], 1);

    // Bounce on channel 1: 3-cycle toggles, then held.
    clearCounts();
    for (int k = 0; k < 10; k++) begin
      applyStimulus((k % 2 == 0) ? 4'b0010 : 4'b0000, 3, "bounce");
    end
    checkCount("bounce_no_pulse", pulseCount[1], 0);
    applyStimulus(4'b0010, 9, "bounce_hold");
    checkOutput("bounce_e9_est", oEstables, 4'b0000);
    tick("bounce_hold");
    checkOutput("bounce_e10_est", oEstables, 4'b0010);
    checkOutput("bounce_e10_pul", oPulsos, 4'b0010);
    applyStimulus(4'b0010, 3, "bounce_hold");
    checkCount("bounce_pulse_count", pulseCount[1], 1);
    applyStimulus(4'b0000, 12, "bounce_rel");

    // Glitch widths on channel 2: C-1 rejected, C accepted.
    clearCounts();
    applyStimulus(4'b0100, 7, "glitch7");
    applyStimulus(4'b0000, 12, "glitch7_low");
    checkCount("glitch7_pulse_count", pulseCount[2], 0);
    checkOutput("glitch7_est", oEstables, 4'b0000);
    applyStimulus(4'b0100, 8, "glitch8");
    applyStimulus(4'b0000, 1, "glitch8_low");
    checkOutput("glitch8_e9_est", oEstables, 4'b0000);
    tick("glitch8_low");
    checkOutput("glitch8_e10_est", oEstables, 4'b0100);
    checkOutput("glitch8_e10_pul", oPulsos, 4'b0100);
    applyStimulus(4'b0000, 7, "glitch8_low");
    checkOutput("glitch8_e17_est", oEstables, 4'b0100);
    tick("glitch8_low");
    checkOutput("glitch8_e18_est", oEstables, 4'b0000);
    checkCount("glitch8_pulse_count", pulseCount[2], 1);
    applyStimulus(4'b0000, 4, "glitch8_low");

    // Simultaneous press on channels 0 and 3.
    clearCounts();
    applyStimulus(4'b1001, 9, "simul");
    tick("simul");
    checkOutput("simul_e10_pul", oPulsos, 4'b1001);
    checkOutput("simul_e10_est", oEstables, 4'b1001);
    tick("simul");
    checkOutput("simul_e11_pul", oPulsos, 4'b0000);
    applyStimulus(4'b0000, 12, "simul_rel");
    checkCount("simul_ch0", pulseCount[0], 1);
    checkCount("simul_ch1", pulseCount[1], 0);
    checkCount("simul_ch2", pulseCount[2], 0);
    checkCount("simul_ch3", pulseCount[3], 1);

    // Reset in the middle of validating channel 1.
    clearCounts();
    applyStimulus(4'b0010, 5, "midrst_pre");
    iReset = 1'b0;
    #1;
    modelReset();
    checkOutput("midrst_async_est", oEstables, 4'b0000);
    checkOutput("midrst_async_pul", oPulsos, 4'b0000);
    applyStimulus(4'b0010, 2, "midrst_hold");
    iReset = 1'b1;
    clearCounts();
    applyStimulus(4'b0010, 9, "midrst_rel");
    checkOutput("midrst_e9_est", oEstables, 4'b0000);
    checkCount("midrst_no_early_pulse", pulseCount[1], 0);
    tick("midrst_rel");
    checkOutput("midrst_e10_est", oEstables, 4'b0010);
    checkOutput("midrst_e10_pul", oPulsos, 4'b0010);
    tick("midrst_rel");
    checkCount("midrst_pulse_count", pulseCount[1], 1);

    checkCount("scoreboard_drained", scoreboard.size(), 0);
    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
